// File: rtl/board_mem_arbiter.sv
// Board RAM arbiter for the 15x15 game board: video reads own fixed slots, game-logic writes
// and full-board clears use the remaining free cycles of the single-port RAM.
module board_mem_arbiter (
    input  logic        clk_25M,
    input  logic        rst_p,
    input  logic [11:0] pixel_x,
    input  logic [11:0] pixel_y,
    input  logic        video_on,
    input  logic        wr_req,
    input  logic [3:0]  wr_row,
    input  logic [3:0]  wr_col,
    input  logic [1:0]  wr_data,
    input  logic        clr_req,
    output logic        wr_ack,
    output logic        wr_err,
    output logic        busy,
    output logic        clr_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [1:0]  mem_wdata,
    input  logic [1:0]  mem_rdata,
    output logic [1:0]  cell_state
);

    typedef enum logic [1:0] {StIdle, StWrite, StAck, StClear} state_e;

    localparam logic [7:0] LastAddr = 8'd224;

    state_e     state_q, state_d;
    logic [7:0] clr_addr_q, clr_addr_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    logic       rd_pend_q;
    logic [1:0] cell_q;

    logic [11:0] x_off;
    logic        video_slot;
    logic        wr_in_range;

    function automatic logic [7:0] cell_addr(input logic [3:0] row, input logic [3:0] col);
        return ({row, 4'b0000} - {4'b0000, row}) + {4'b0000, col};
    endfunction

    // Slots sit two pixels ahead of each cell so the data is registered before the cell starts.
    // Wrap-around of x_off below 78 makes the single upper-bound compare sufficient.
    assign x_off       = pixel_x - 12'd78;
    assign video_slot  = video_on && (pixel_y < 12'd480) && (x_off <= 12'd448)
                         && (x_off[4:0] == 5'd0);
    assign wr_in_range = (wr_row <= 4'd14) && (wr_col <= 4'd14);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        err_d      = err_q;
        done_d     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'd0;
        mem_wdata  = 2'd0;
        wr_ack     = 1'b0;
        wr_err     = 1'b0;

        if (video_slot) begin
            mem_en   = 1'b1;
            mem_addr = cell_addr(pixel_y[8:5], x_off[8:5]);
        end

        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d    = StClear;
                    clr_addr_d = 8'd0;
                end else if (wr_req) begin
                    state_d = wr_in_range ? StWrite : StAck;
                    err_d   = !wr_in_range;
                end
            end
            StWrite: begin
                if (!video_slot) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cell_addr(wr_row, wr_col);
                    mem_wdata = wr_data;
                    state_d   = StAck;
                end
            end
            StAck: begin
                wr_ack  = 1'b1;
                wr_err  = err_q;
                state_d = StIdle;
            end
            StClear: begin
                if (!video_slot) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = clr_addr_q;
                    mem_wdata = 2'd0;
                    if (clr_addr_q == LastAddr) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        clr_addr_d = clr_addr_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (rst_p) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk_25M) begin
        if (rst_p) begin
            state_q    <= StIdle;
            clr_addr_q <= 8'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            cell_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            err_q      <= err_d;
            done_q     <= done_d;
            rd_pend_q  <= video_slot;
            if (rd_pend_q) begin
                cell_q <= mem_rdata;
            end
        end
    end

    assign busy       = (state_q == StClear);
    assign clr_done   = done_q;
    assign cell_state = (video_on && (pixel_x >= 12'd80) && (pixel_x < 12'd560)) ? cell_q : 2'd0;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural single-port RAM behind the DUT.
module tb_board_mem_arbiter;

    logic        clk_25M = 1'b0;
    logic        rst_p;
    logic [11:0] pixel_x, pixel_y;
    logic        video_on, wr_req, clr_req;
    logic [3:0]  wr_row, wr_col;
    logic [1:0]  wr_data;
    logic        wr_ack, wr_err, busy, clr_done, mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_wdata, mem_rdata, cell_state;

    logic [1:0]  ram [0:255];

    int tests = 0;
    int fails = 0;

    always #20 clk_25M = ~clk_25M;

    board_mem_arbiter dut (
        .clk_25M    (clk_25M),
        .rst_p      (rst_p),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .wr_req     (wr_req),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .clr_req    (clr_req),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .busy       (busy),
        .clr_done   (clr_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cell_state (cell_state)
    );

    always @(posedge clk_25M) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25M);
        #2;
    endtask

    function automatic logic tb_slot(input logic v, input int x, input int y);
        return v && (y < 480) && (x >= 78) && (x <= 526) && (((x - 78) % 32) == 0);
    endfunction

    initial begin
        int  p, exp_addr, nclr, bad_seq, nslot_wr, busy_gap, ndone, post_write;
        logic done_seen, ack_seen, ack_err, found;

        rst_p = 1'b1; video_on = 1'b1; pixel_x = 12'd78; pixel_y = 12'd0;
        wr_req = 1'b0; clr_req = 1'b0; wr_row = 4'd0; wr_col = 4'd0; wr_data = 2'd0;
        step(); step(); #1;
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_wr_ack", wr_ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_clr_done", clr_done, 1'b0);

        // Plain write in blanking: addr 3*15+4 = 49.
        rst_p = 1'b0; video_on = 1'b0; pixel_x = 12'd10;
        wr_req = 1'b1; wr_row = 4'd3; wr_col = 4'd4; wr_data = 2'd1;
        #1; check("idle_no_traffic", mem_en, 1'b0);
        step(); pixel_x = 12'd11; #1;
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_en", mem_en, 1'b1);
        check("wr_addr", mem_addr, 8'd49);
        check("wr_wdata", mem_wdata, 2'd1);
        check("wr_no_early_ack", wr_ack, 1'b0);
        step(); pixel_x = 12'd12; #1;
        check("wr_ack", wr_ack, 1'b1);
        check("wr_err_clear", wr_err, 1'b0);
        check("ack_no_we", mem_we, 1'b0);
        wr_req = 1'b0;
        step(); #1; check("ack_one_cycle", wr_ack, 1'b0);

        // Write colliding with slot k=1 at x=110: cell (2,1)=1, addr 31.
        video_on = 1'b1; pixel_y = 12'd0; pixel_x = 12'd109;
        wr_req = 1'b1; wr_row = 4'd2; wr_col = 4'd1; wr_data = 2'd1;
        step(); pixel_x = 12'd110; #1;
        check("slot_read_en", mem_en, 1'b1);
        check("slot_no_we", mem_we, 1'b0);
        check("slot_read_addr", mem_addr, 8'd1);
        step(); pixel_x = 12'd111; #1;
        check("defer_we", mem_we, 1'b1);
        check("defer_addr", mem_addr, 8'd31);
        step(); pixel_x = 12'd112; #1;
        check("defer_ack", wr_ack, 1'b1);
        wr_req = 1'b0;
        step();

        // Cell (2,0)=2, addr 30.
        video_on = 1'b0; pixel_x = 12'd10;
        wr_req = 1'b1; wr_row = 4'd2; wr_col = 4'd0; wr_data = 2'd2;
        step(); #1;
        check("pre_addr", mem_addr, 8'd30);
        check("pre_we", mem_we, 1'b1);
        step(); #1;
        check("pre_ack", wr_ack, 1'b1);
        wr_req = 1'b0;
        step();

        // Scan line y=70 (row 2).
        video_on = 1'b1; pixel_y = 12'd70;
        for (int x = 76; x <= 145; x++) begin
            pixel_x = 12'(x); #1;
            if (x == 79) check("cell_x79", cell_state, 2'd0);
            else if (x >= 80 && x <= 111) check("cell_c0", cell_state, 2'd2);
            else if (x >= 112 && x <= 143) check("cell_c1", cell_state, 2'd1);
            step();
        end
        pixel_x = 12'd560; #1; check("cell_x560", cell_state, 2'd0);
        step();

        // Out-of-range row.
        video_on = 1'b0; pixel_x = 12'd10;
        wr_req = 1'b1; wr_row = 4'd15; wr_col = 4'd0; wr_data = 2'd1;
        #1; check("err_idle_no_we", mem_we, 1'b0);
        step(); #1;
        check("err_ack", wr_ack, 1'b1);
        check("err_flag", wr_err, 1'b1);
        check("err_no_we", mem_we, 1'b0);
        wr_req = 1'b0;
        step();

        // Clear with simultaneous write of (1,1)=3 (addr 16) during active video.
        video_on = 1'b1; pixel_y = 12'd0; pixel_x = 12'd0; p = 1;
        clr_req = 1'b1; wr_req = 1'b1; wr_row = 4'd1; wr_col = 4'd1; wr_data = 2'd3;
        step(); clr_req = 1'b0;
        exp_addr = 0; nclr = 0; bad_seq = 0; nslot_wr = 0; busy_gap = 0; ndone = 0;
        post_write = 0; done_seen = 1'b0; ack_seen = 1'b0; ack_err = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            pixel_x = 12'(p); p = (p + 1) % 800; #1;
            if (clr_done) begin ndone++; done_seen = 1'b1; end
            if (mem_en && mem_we) begin
                if (tb_slot(video_on, int'(pixel_x), int'(pixel_y))) nslot_wr++;
                if (!done_seen) begin
                    if (mem_wdata != 2'd0 || int'(mem_addr) != exp_addr) bad_seq++;
                    exp_addr++; nclr++;
                end else if (mem_addr == 8'd16 && mem_wdata == 2'd3) post_write++;
            end
            if (!done_seen && !busy) busy_gap++;
            if (wr_ack) begin
                ack_seen = 1'b1; ack_err = wr_err; wr_req = 1'b0;
                step();
                break;
            end
            step();
        end
        check("clr_count", nclr, 225);
        check("clr_seq", bad_seq, 0);
        check("clr_no_slot_write", nslot_wr, 0);
        check("clr_busy_hold", busy_gap, 0);
        check("clr_done_pulses", ndone, 1);
        check("pending_write", post_write, 1);
        check("pending_ack", ack_seen, 1'b1);
        check("pending_ack_err", ack_err, 1'b0);

        // Reset in the middle of a clear.
        video_on = 1'b0; pixel_x = 12'd10;
        clr_req = 1'b1; step(); clr_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            #1;
            if (mem_we && mem_addr == 8'd100) found = 1'b1;
            else step();
        end
        check("clr_reach_100", found, 1'b1);
        rst_p = 1'b1; #1;
        check("rst_mid_en", mem_en, 1'b0);
        step(); video_on = 1'b1; pixel_x = 12'd78; #1;
        check("rst_busy_drop", busy, 1'b0);
        check("rst_no_done", clr_done, 1'b0);
        check("rst_slot_en", mem_en, 1'b0);
        step(); #1;
        check("rst_hold_done", clr_done, 1'b0);
        check("rst_hold_en", mem_en, 1'b0);
        rst_p = 1'b0; video_on = 1'b0; pixel_x = 12'd10; #1;
        check("post_rst_idle_en", mem_en, 1'b0);
        step(); #1;
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", clr_done, 1'b0);
        check("post_rst_no_we", mem_we, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 Clocking and reset: one clock; reset is synchronous and active-high. clk_25M is the single clock and rst_p is the reset.
REQ-002 clk_25M  in  1  25 MHz pixel clock; all state updates on its rising edge.
REQ-003 rst_p  in  1  synchronous active-high reset.
REQ-004 pixel_x  in  12  horizontal scan position from the VGA timing generator.
REQ-005 pixel_y  in  12  vertical scan position from the VGA timing generator.
REQ-006 video_on  in  1  display-area flag from the VGA timing generator.
REQ-007 wr_req  in  1  game-logic write request; level, held until wr_ack.
REQ-008 wr_row, wr_col  in  4 each  target cell; must be stable while wr_req=1.
REQ-009 wr_data  in  2  cell value: 0 empty, 1 black, 2 white, 3 reserved (written as given).
REQ-010 clr_req  in  1  single-cycle pulse requesting a full-board clear.
REQ-011 wr_ack  out  1  one-cycle pulse: write request retired.
REQ-012 wr_err  out  1  qualifies wr_ack: coordinates out of range, no write performed.
REQ-013 busy  out  1  high while a clear is in progress.
REQ-014 clr_done  out  1  one-cycle pulse: clear finished.
REQ-015 mem_en, mem_we  out  1 each  single-port board RAM enable and write enable.
REQ-016 mem_addr  out  8  RAM address = row*15+col, range 0..224.
REQ-017 mem_wdata  out  2  RAM write data.
REQ-018 mem_rdata  in  2  RAM read data, valid exactly 1 cycle after a read (mem_en=1, mem_we=0).
REQ-019 cell_state  out  2  board value for the pixel currently presented on pixel_x/pixel_y.

Function
REQ-020 Board geometry: 15x15 cells of 32x32 px. Board area is x=80..559, y=0..479; col=(x-80)>>5, row=y>>5.
REQ-021 Video slot: the cycle with video_on=1, pixel_y<480 and pixel_x==78+32k (k=0..14). In that cycle the block drives mem_en=1, mem_we=0 and mem_addr=(pixel_y>>5)*15+k combinationally.
REQ-022 Video slots have absolute priority; no write is issued in a video slot.
REQ-023 Read data returned in the cycle pixel_x==79+32k is registered into the internal cell register. cell_state therefore equals cell (row,k) for pixel_x 80+32k..111+32k; read-to-display latency is 2 cycles.
REQ-024 cell_state is forced to 0 combinationally when video_on=0, pixel_x<80 or pixel_x>=560.
REQ-025 Free cycle: any cycle that is not a video slot. Write and clear traffic uses free cycles only; mem_en=0 when a free cycle is unused.
REQ-026 FSM states are IDLE, WRITE, ACK and CLEAR.
REQ-027 IDLE transitions: clr_req=1 -> CLEAR with clear address 0 (clr_req wins if wr_req=1 in the same cycle). Otherwise wr_req=1 with wr_row<=14 and wr_col<=14 -> WRITE. Otherwise wr_req=1 with either coordinate >14 -> ACK with the error flag set.
REQ-028 WRITE: in the first free cycle, drive mem_en=1, mem_we=1, mem_addr=wr_row*15+wr_col, mem_wdata=wr_data, then go to ACK. Remain in WRITE while the cycle is a video slot.
REQ-029 ACK: wr_ack=1 for one cycle and wr_err=error flag, then go to IDLE. wr_req is ignored in ACK. Minimum latency is 2 cycles from wr_req sampled in IDLE to wr_ack.
REQ-030 CLEAR: in each free cycle write 0 to the clear address, then increment it. After the write to address 224, assert clr_done for one cycle (the next cycle) and return to IDLE.
REQ-031 Inputs ignored while not in IDLE: wr_req is not serviced during CLEAR; a held wr_req is serviced after the clear. clr_req pulses arriving outside IDLE are dropped.
REQ-032 busy=1 in CLEAR only, including the cycle of the final write.
REQ-033 Address arithmetic: row*15+col is computed at 8 bits without overflow (max 224). The clear address counter is 8 bits and never exceeds 224.

Reset
REQ-034 While rst_p=1 at a clock edge, the next state is: FSM=IDLE, clear address=0, cell register=0, error flag=0; wr_ack, wr_err, busy and clr_done are 0.
REQ-035 Memory outputs during reset: mem_en=0 and mem_we=0 while rst_p=1, regardless of the scan position.
REQ-036 Reset mid-clear aborts the clear: no clr_done is issued, and the RAM is left partially cleared.
REQ-037 Reset between WRITE and ACK drops the request without wr_ack; the requester must re-request.

Verification
REQ-038 wr_req, row 3, col 4, data 1, issued at pixel_x=10, video_on=0 -> mem_we=1 with addr 49 and wdata 1 one cycle later, wr_ack 2 cycles after wr_req.
REQ-039 wr_req timed so that WRITE coincides with pixel_x=110 (video slot k=1) -> write deferred to pixel_x=111, no mem_we in the slot cycle.
REQ-040 Preload cell (2,0)=2 and cell (2,1)=1; scan line y=70 -> cell_state=0 at x=79, 2 for x=80..111, 1 for x=112..143, 0 at x=560.
REQ-041 wr_req with row 15, col 0 -> wr_ack=1 and wr_err=1, no mem_we.
REQ-042 clr_req and wr_req together -> exactly 225 zero-writes to addresses 0..224 in free cycles only, busy high throughout, one clr_done pulse, then the pending write is acked.
REQ-043 rst_p asserted at clear address 100 -> busy=0 next cycle, no clr_done, FSM idle, mem_en=0 while reset is held.
